button_debouncer_array: RTL and testbench

Multi-channel, parametrised debouncer for the board's push-buttons and switches. It feeds the display-mode and counter control logic. Each channel synchronises its raw pin, rejects bounce shorter than a programmable settle time, and reports a stable level. It also reports one-cycle press/release pulses and a one-shot long-press pulse, so downstream FSMs need no edge detectors of their own.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/button_debouncer_array_if.sv | 31 +++
 rtl/debounce_channel.sv | 109 ++++++++++
 rtl/button_debouncer_array.sv | 72 +++++++
 tb/tb_button_debouncer_array.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the button debouncer array:
//   - settle FSM state encoding (kept as plain 1-bit constants so older
//     blocks that compare against raw bit values keep working)
//   - min_cnt_w(): smallest counter width able to hold both the settle
//     count and the long-press hold count without wrapping
// ---------------------------------------------------------------------------
package debounce_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  // Smallest w with 2^w > max(debounce_cycles, long_cycles).
  function automatic int min_cnt_w(input int debounce_cycles, input int long_cycles);
    int m;
    int w;
    m = (debounce_cycles > long_cycles) ? debounce_cycles : long_cycles;
    w = 1;
    while ((w < 31) && ((1 << w) <= m)) w++;
    return w;
  endfunction

endpackage

// File: rtl/button_debouncer_array_if.sv
// ---------------------------------------------------------------------------
// button_debouncer_array_if
// Bundles the raw button pins and the debounced level / pulse outputs.
//   button_in     : raw asynchronous pin levels         (master -> slave)
//   debounced_out : stable level, 1 = pressed            (slave -> master)
//   rise_pulse    : one-cycle pulse on 0->1 of debounced (slave -> master)
//   fall_pulse    : one-cycle pulse on 1->0 of debounced (slave -> master)
//   long_press    : one-shot pulse per sustained press   (slave -> master)
//   any_event     : OR of all pulse bits                 (slave -> master)
// The debouncer is the slave; the board / test environment is the master.
// ---------------------------------------------------------------------------
interface button_debouncer_array_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] button_in;
  logic [CHANNELS-1:0] debounced_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] long_press;
  logic                any_event;

  modport master (
    output button_in,
    input  debounced_out, rise_pulse, fall_pulse, long_press, any_event
  );

  modport slave (
    input  button_in,
    output debounced_out, rise_pulse, fall_pulse, long_press, any_event
  );
endinterface

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One debouncer lane: synchroniser, two-state settle FSM, long-press hold
// counter and registered rise/fall/long pulses.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_raw        : raw level, already polarity-corrected (1 = pressed)
//   o_debounced  : accepted stable level
//   o_rise       : one-cycle pulse when o_debounced goes 0->1
//   o_fall       : one-cycle pulse when o_debounced goes 1->0
//   o_long       : one-cycle pulse once per press after LONG_CYCLES held
// ---------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int LONG_CYCLES     = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_debounced,
  output logic o_rise,
  output logic o_fall,
  output logic o_long
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [0:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hold;
  logic                   r_deb;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_long;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Settle FSM: a mismatch must survive DEBOUNCE_CYCLES+1 consecutive samples
  // (one to enter SETTLE, DEBOUNCE_CYCLES in SETTLE) before it is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_deb   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s != r_deb) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (w_s == r_deb) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == DB_LAST) begin
            r_deb   <= w_s;
            r_rise  <= w_s;
            r_fall  <= ~w_s;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Hold counter saturates at LONG_CYCLES, so the one-shot cannot repeat
  // within a single press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_deb) begin
        r_hold <= '0;
      end else if (r_hold != HOLD_MAX) begin
        r_hold <= r_hold + CNT_W'(1);
        r_long <= (r_hold == HOLD_LAST);
      end
    end
  end

  assign o_debounced = r_deb;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign o_long      = r_long;

endmodule

// File: rtl/button_debouncer_array.sv
// ---------------------------------------------------------------------------
// button_debouncer_array
// Multi-channel debouncer for push-buttons and switches. Each channel is an
// independent debounce_channel; ACTIVE_LOW bits invert the raw pin so that
// every output uses 1 = pressed.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : slave side of button_debouncer_array_if (button_in in;
//           debounced_out, rise_pulse, fall_pulse, long_press, any_event out)
// ---------------------------------------------------------------------------
module button_debouncer_array
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS        = 4,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 100,
  parameter int                  LONG_CYCLES     = 500000,
  parameter int                  CNT_W           = 20,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW      = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  button_debouncer_array_if.slave bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("LONG_CYCLES must be at least 1");
  end
  if (CNT_W < min_cnt_w(DEBOUNCE_CYCLES, LONG_CYCLES)) begin : g_bad_cnt
    $error("CNT_W too small for DEBOUNCE_CYCLES/LONG_CYCLES");
  end

  logic [CHANNELS-1:0] w_raw;
  logic [CHANNELS-1:0] w_deb;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_long;

  assign w_raw = bus.button_in ^ ACTIVE_LOW;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_raw      (w_raw[g]),
      .o_debounced(w_deb[g]),
      .o_rise     (w_rise[g]),
      .o_fall     (w_fall[g]),
      .o_long     (w_long[g])
    );
  end

  assign bus.debounced_out = w_deb;
  assign bus.rise_pulse    = w_rise;
  assign bus.fall_pulse    = w_fall;
  assign bus.long_press    = w_long;
  // OR of registered pulse bits only; nothing here sees button_in directly.
  assign bus.any_event     = |{w_rise, w_fall, w_long};

endmodule

// File: tb/tb_button_debouncer_array.sv
module tb_button_debouncer_array;

  localparam int          CH   = 2;
  localparam int          SYNC = 2;
  localparam int          DB   = 4;
  localparam int          LC   = 10;
  localparam logic [1:0]  AL   = 2'b10;
  localparam logic [1:0]  REL  = 2'b10;   // both buttons released at the pins

  typedef struct packed {
    logic [1:0] deb;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] lng;
    logic       any;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_debouncer_array_if #(.CHANNELS(CH)) bus ();

  button_debouncer_array #(
    .CHANNELS       (CH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC),
    .CNT_W          (4),
    .ACTIVE_LOW     (AL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model: per channel, a pin-to-sample delay line, the length of
  // the current run of samples disagreeing with the accepted level, and the
  // number of cycles the accepted level has been "pressed".
  logic [SYNC-1:0] m_line [CH];
  int              m_run  [CH];
  int              m_held [CH];
  logic            m_deb  [CH];

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_rises = 0, m_falls = 0, m_longs = 0;
  int   d_rises = 0, d_falls = 0, d_longs = 0;
  int   cyc = 0;

  task automatic model_step(input logic [1:0] raw, input logic rst);
    exp_t e;
    logic s, pre;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_line[c] = '0;
        m_run[c]  = 0;
        m_held[c] = 0;
        m_deb[c]  = 1'b0;
      end else begin
        s   = m_line[c][SYNC-1];
        m_line[c] = {m_line[c][SYNC-2:0], raw[c] ^ AL[c]};
        pre = m_deb[c];
        if (pre) begin
          if (m_held[c] < LC) begin
            m_held[c]++;
            if (m_held[c] == LC) e.lng[c] = 1'b1;
          end
        end else begin
          m_held[c] = 0;
        end
        if (s != pre) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_deb[c] = s;
            if (s) e.rise[c] = 1'b1;
            else   e.fall[c] = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      e.deb[c] = m_deb[c];
    end
    e.any = |{e.rise, e.fall, e.lng};
    m_rises += $countones(e.rise);
    m_falls += $countones(e.fall);
    m_longs += $countones(e.lng);
    q.push_back(e);
  endtask

  task automatic tick(input logic [1:0] raw, input logic rst);
    @(negedge clk);
    #1;
    bus.button_in = raw;
    reset         = rst;
    @(posedge clk);
    model_step(raw, rst);
  endtask

  task automatic drive(input logic [1:0] raw, input int n);
    for (int i = 0; i < n; i++) tick(raw, 1'b0);
  endtask

  // Monitor: the DUT presents its outputs every cycle; compare at negedge.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {bus.debounced_out, bus.rise_pulse, bus.fall_pulse,
               bus.long_press, bus.any_event};
        d_rises += $countones(bus.rise_pulse);
        d_falls += $countones(bus.fall_pulse);
        d_longs += $countones(bus.long_press);
        n_checks++;
        if (got === e) n_pass++;
        else $display("FAIL outputs cyc=%0d got deb=%b rise=%b fall=%b long=%b any=%b exp deb=%b rise=%b fall=%b long=%b any=%b",
                      cyc, got.deb, got.rise, got.fall, got.lng, got.any,
                      e.deb, e.rise, e.fall, e.lng, e.any);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] r;
    reset         = 1'b0;
    bus.button_in = REL;
    #2 reset = 1'b1;

    // Reset, then idle with both buttons released.
    for (int i = 0; i < 3; i++) tick(REL, 1'b1);
    drive(REL, 20);

    // Clean press on ch0 held well past long-press, then release.
    drive(2'b11, 45);
    drive(REL, 15);

    // Bounce on ch0: 1,0,1,1,0 then released.
    tick(2'b11, 1'b0); tick(2'b10, 1'b0); tick(2'b11, 1'b0);
    tick(2'b11, 1'b0); tick(2'b10, 1'b0);
    drive(REL, 12);

    // Simultaneous press: ch0 high, ch1 pin low (active-low).
    drive(2'b01, 20);
    drive(REL, 15);

    // Reset mid-SETTLE with ch0 held; after release, re-debounce from scratch.
    drive(2'b11, 5);
    tick(2'b11, 1'b1);
    tick(2'b11, 1'b1);
    drive(2'b11, 20);
    drive(REL, 12);

    // Reset mid-hold.
    drive(2'b01, 12);
    tick(2'b01, 1'b1);
    drive(2'b01, 25);
    drive(REL, 12);

    // Randomised: bouncy phase then slow phase with long holds.
    r = REL;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) r[0] = ~r[0];
      if ($urandom_range(0, 2) == 0) r[1] = ~r[1];
      tick(r, $urandom_range(0, 149) == 0);
    end
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) r[0] = ~r[0];
      if ($urandom_range(0, 23) == 0) r[1] = ~r[1];
      tick(r, $urandom_range(0, 299) == 0);
    end
    drive(REL, 12);

    // Drain the scoreboard.
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain got %0d pending required 0", q.size());
    n_checks++;
    if (d_rises == m_rises) n_pass++;
    else $display("FAIL rise_count got %0d required %0d", d_rises, m_rises);
    n_checks++;
    if (d_falls == m_falls) n_pass++;
    else $display("FAIL fall_count got %0d required %0d", d_falls, m_falls);
    n_checks++;
    if (d_longs == m_longs) n_pass++;
    else $display("FAIL long_count got %0d required %0d", d_longs, m_longs);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
